// File: rtl/lagd_banked_mem_ctrl.sv
// Multi-port, word-interleaved multi-bank SRAM controller with per-bank round-robin
// arbitration, fixed access latency, out-of-range error responses and a conflict counter.
module lagd_banked_mem_ctrl #(
  parameter int unsigned NumPorts          = 2,
  parameter int unsigned NumBanks          = 4,
  parameter int unsigned WordsPerBank      = 2048,
  parameter int unsigned DataWidth         = 64,
  parameter int unsigned AddrWidth         = 32,
  parameter int unsigned BankAccessLatency = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumPorts-1:0]             req_i,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*DataWidth/8-1:0] be_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  output logic [NumPorts-1:0]             gnt_o,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [NumPorts*DataWidth-1:0]   rdata_o,
  output logic [NumPorts-1:0]             err_o,
  input  logic                            cnt_clr_i,
  output logic [31:0]                     conflict_cnt_o
);

  localparam int unsigned BeW      = DataWidth / 8;
  localparam int unsigned BoBits   = $clog2(BeW);
  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned RowBits  = $clog2(WordsPerBank);
  localparam int unsigned BankW    = (BankBits == 0) ? 1 : BankBits;
  localparam int unsigned RowW     = (RowBits == 0) ? 1 : RowBits;
  localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned Lat      = BankAccessLatency;

  logic [AddrWidth-1:0] waddr_c [NumPorts];
  logic [BankW-1:0]     bank_c  [NumPorts];
  logic [RowW-1:0]      row_c   [NumPorts];
  logic [NumPorts-1:0]  oor_c;

  // Word address split into bank (low bits) and row; anything above the row is out of range
  always_comb begin : decode
    for (int p = 0; p < NumPorts; p++) begin
      waddr_c[p] = addr_i[p*AddrWidth +: AddrWidth] >> BoBits;
      bank_c[p]  = BankW'(waddr_c[p] & AddrWidth'(NumBanks - 1));
      row_c[p]   = RowW'((waddr_c[p] >> BankBits) & AddrWidth'(WordsPerBank - 1));
      oor_c[p]   = (waddr_c[p] >> (BankBits + RowBits)) != '0;
    end
  end

  logic [PortW-1:0]     ptr_q        [NumBanks];
  logic [PortW-1:0]     ptr_d        [NumBanks];
  logic [PortW-1:0]     winner_c     [NumBanks];
  logic [NumBanks-1:0]  bank_gnt_c;
  logic [NumBanks-1:0]  bank_we_c;
  logic [RowW-1:0]      bank_row_c   [NumBanks];
  logic [BeW-1:0]       bank_be_c    [NumBanks];
  logic [DataWidth-1:0] bank_wdata_c [NumBanks];
  logic [NumPorts-1:0]  gnt_c;

  // Per-bank round-robin search starting at the pointer, then route the winner's write
  always_comb begin : arbitrate
    logic [PortW:0] cand;
    logic           found;
    cand  = '0;
    found = 1'b0;
    gnt_c = req_i & oor_c;
    for (int b = 0; b < NumBanks; b++) begin
      found           = 1'b0;
      winner_c[b]     = '0;
      ptr_d[b]        = ptr_q[b];
      bank_we_c[b]    = 1'b0;
      bank_row_c[b]   = '0;
      bank_be_c[b]    = '0;
      bank_wdata_c[b] = '0;
      for (int i = 0; i < NumPorts; i++) begin
        cand = {1'b0, ptr_q[b]} + (PortW+1)'(i);
        if (cand >= (PortW+1)'(NumPorts)) cand = cand - (PortW+1)'(NumPorts);
        if (!found && req_i[cand[PortW-1:0]] && !oor_c[cand[PortW-1:0]] &&
            bank_c[cand[PortW-1:0]] == BankW'(b)) begin
          found       = 1'b1;
          winner_c[b] = cand[PortW-1:0];
        end
      end
      bank_gnt_c[b] = found;
      for (int p = 0; p < NumPorts; p++) begin
        if (found && winner_c[b] == PortW'(p)) begin
          gnt_c[p]        = 1'b1;
          bank_we_c[b]    = we_i[p];
          bank_row_c[b]   = row_c[p];
          bank_be_c[b]    = be_i[p*BeW +: BeW];
          bank_wdata_c[b] = wdata_i[p*DataWidth +: DataWidth];
        end
      end
      if (found) begin
        ptr_d[b] = (winner_c[b] == PortW'(NumPorts - 1)) ? '0 : winner_c[b] + PortW'(1);
      end
    end
  end

  assign gnt_o = gnt_c;

  logic [DataWidth-1:0] mem_q [NumBanks][WordsPerBank];

  always_ff @(posedge clk_i) begin : bank_write
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_gnt_c[b] && bank_we_c[b]) begin
        for (int k = 0; k < BeW; k++) begin
          if (bank_be_c[b][k]) mem_q[b][bank_row_c[b]][k*8 +: 8] <= bank_wdata_c[b][k*8 +: 8];
        end
      end
    end
  end

  logic [NumPorts-1:0]           vld_q [Lat];
  logic [NumPorts-1:0]           vld_d [Lat];
  logic [NumPorts-1:0]           err_q [Lat];
  logic [NumPorts-1:0]           err_d [Lat];
  logic [NumPorts*DataWidth-1:0] dat_q [Lat];
  logic [NumPorts*DataWidth-1:0] dat_d [Lat];
  logic [31:0]                   cnt_q;
  logic [31:0]                   cnt_d;

  // Stage 0 samples the array at the grant edge; later stages only delay the response
  always_comb begin : resp_pipe
    vld_d[0] = gnt_c;
    err_d[0] = gnt_c & oor_c;
    dat_d[0] = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (gnt_c[p] && !oor_c[p] && !we_i[p]) begin
        dat_d[0][p*DataWidth +: DataWidth] = mem_q[bank_c[p]][row_c[p]];
      end
    end
    for (int s = 1; s < Lat; s++) begin
      vld_d[s] = vld_q[s-1];
      err_d[s] = err_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
  end

  always_comb begin : conflict_count
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (|(req_i & ~gnt_c) && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++) ptr_q[b] <= '0;
      for (int s = 0; s < Lat; s++) begin
        vld_q[s] <= '0;
        err_q[s] <= '0;
        dat_q[s] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) ptr_q[b] <= ptr_d[b];
      for (int s = 0; s < Lat; s++) begin
        vld_q[s] <= vld_d[s];
        err_q[s] <= err_d[s];
        dat_q[s] <= dat_d[s];
      end
      cnt_q <= cnt_d;
    end
  end

  assign rvalid_o       = vld_q[Lat-1];
  assign err_o          = err_q[Lat-1];
  assign rdata_o        = dat_q[Lat-1];
  assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/lagd_banked_mem_ctrl.md
Name: lagd_banked_mem_ctrl

Overview:
Multi-port, multi-bank on-chip SRAM controller. It generalises the single-bank memory-island configuration to NumBanks word-interleaved banks shared by NumPorts OBI-style requestors. Per-bank round-robin arbitration, a configurable fixed access latency, out-of-range error responses and a bank-conflict performance counter are included. Intended for L2, core stack and Ising-core L1 instances.

Parameters:
- NumPorts, 2, number of requestor ports (>=1).
- NumBanks, 4, number of banks; power of two, >=1.
- WordsPerBank, 2048, words per bank; power of two.
- DataWidth, 64, word width in bits; multiple of 8.
- AddrWidth, 32, byte-address width per port.
- BankAccessLatency, 1, cycles from grant to rvalid; >=1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumPorts  request valid per port
- addr_i  in  NumPorts*AddrWidth  byte address per port
- we_i  in  NumPorts  1 = write
- be_i  in  NumPorts*DataWidth/8  byte enables
- wdata_i  in  NumPorts*DataWidth  write data
- gnt_o  out  NumPorts  request accepted this cycle
- rvalid_o  out  NumPorts  response valid
- rdata_o  out  NumPorts*DataWidth  read data
- err_o  out  NumPorts  response is an error (qualified by rvalid_o)
- cnt_clr_i  in  1  synchronous clear of conflict counter
- conflict_cnt_o  out  32  bank-conflict cycle counter

Behaviour:
- Clocking and reset: single clock domain, asynchronous active-low reset on rst_ni. Reset is the only asynchronous input.
- Address map:
  - BO = log2(DataWidth/8) byte-offset bits, ignored.
  - Bank = addr[BO +: log2 NumBanks].
  - Row = addr[BO+log2 NumBanks +: log2 WordsPerBank].
  - Any nonzero address bit above the row field marks the access out of range.
- Grant (combinational, same cycle as req):
  - In-range request: gnt_o[p]=1 iff port p wins its bank's arbiter.
  - Out-of-range request: gnt_o=1 immediately. It occupies no bank, writes nothing, and never blocks other ports.
- Arbitration:
  - One round-robin arbiter per bank; pointer is 0 after reset.
  - The highest-priority requesting port, starting at the pointer, wins.
  - On a grant the pointer moves to (winner+1) mod NumPorts. With no grant it holds.
  - Losers keep req_i asserted with stable addr/we/be/wdata until granted.
- Access:
  - A write commits in the grant cycle, only bytes with be=1 are updated.
  - A read samples the array at the grant-cycle edge. A write granted in cycle t is visible to a read granted in cycle t+1 or later.
  - Two accesses to the same bank never occur in one cycle. Different banks proceed in parallel.
- Response:
  - rvalid_o[p] is a 1-cycle pulse exactly BankAccessLatency cycles after each gnt_o[p].
  - Fully pipelined: back-to-back grants give back-to-back rvalids, in order per port. No backpressure on responses.
  - Read: rdata = stored word, err=0.
  - Write: rdata='0, err=0.
  - Out of range: rdata='0, err=1.
  - rdata_o and err_o are '0 whenever rvalid_o is 0.
- Conflict counter:
  - Increments by 1 in every cycle where at least one req_i is high with gnt_o low.
  - Saturates at 2^32-1.
  - cnt_clr_i forces it to 0 and has priority over the increment in the same cycle.
- Reset values: gnt_o, rvalid_o, rdata_o, err_o, conflict_cnt_o = 0, arbiter pointers = 0, latency pipeline cleared.
  - Responses in flight when reset asserts are dropped.
  - Array contents are not reset.
- Reset mid-operation: after deassertion, no rvalid is produced for any pre-reset grant.

Test Plan:
- Defaults, port0 writes 0x1122334455667788 (be=0xFF) to 0x08, then reads 0x08 -> gnt same cycle. rvalid 1 cycle after each grant, read rdata=0x1122334455667788, err=0.
- Port0 and port1 both read bank 0 (0x00 and 0x20) every cycle for 4 cycles -> grants alternate p0,p1,p0,p1. conflict_cnt_o=4. Then cnt_clr_i together with a conflict -> counter reads 0.
- Port0 reads 0x00 (bank 0) while port1 reads 0x08 (bank 1) in the same cycle -> both granted, both rvalid next cycle, conflict_cnt_o unchanged.
- Port1 accesses 0x0001_0000 (out of range) -> gnt immediately, rvalid with err=1, rdata=0. A subsequent read of 0x00 shows no corruption.
- Partial write be=0x0F of 0xFFFFFFFFFFFFFFFF over 0x0 -> readback 0x00000000FFFFFFFF. Repeat with BankAccessLatency=3: rvalid exactly 3 cycles after gnt, 3 back-to-back reads give 3 consecutive rvalids.
- Assert rst_ni low one cycle after a grant with BankAccessLatency=2 -> outputs 0 immediately, no rvalid after release, arbiter pointers back at port 0.
